// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus interface.
// Bundles the issue, CDB, operand-query, commit and flush signals shared by the
// reorder buffer and the units around it. Signal names match the ROB's
// original flat port names.
//   slave  : reorder buffer side (consumes issue/CDB/query, produces status,
//            query results, commit pulses and flush)
//   master : surrounding core side (the opposite direction of every signal)
interface reorder_buffer_if;
  // issue
  logic        issue_ready;
  logic [4:0]  issue_rd;
  logic        issue_is_store;
  logic        issue_is_branch;
  logic        issue_pred_jump;
  logic        rob_full;
  logic [3:0]  rob_next_index;
  // common data bus
  logic        cdb_valid;
  logic [3:0]  cdb_rob_index;
  logic [31:0] cdb_val;
  logic        cdb_jump;
  logic [31:0] cdb_target;
  // operand query from decoder
  logic [3:0]  dc_rs1_depend;
  logic [3:0]  dc_rs2_depend;
  logic        rob_rs1_ready;
  logic        rob_rs2_ready;
  logic [31:0] rob_rs1_val;
  logic [31:0] rob_rs2_val;
  // commit
  logic        rob_to_reg_commit;
  logic [3:0]  rob_to_reg_rob_index;
  logic [4:0]  rob_to_reg_index;
  logic [31:0] rob_to_reg_val;
  logic        rob_to_lsb_commit;
  logic [3:0]  rob_to_lsb_rob_index;
  // flush
  logic        rob_clr;
  logic [31:0] rob_to_if_pc;

  modport slave (
    input  issue_ready, issue_rd, issue_is_store, issue_is_branch, issue_pred_jump,
    input  cdb_valid, cdb_rob_index, cdb_val, cdb_jump, cdb_target,
    input  dc_rs1_depend, dc_rs2_depend,
    output rob_full, rob_next_index,
    output rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val,
    output rob_to_reg_commit, rob_to_reg_rob_index, rob_to_reg_index, rob_to_reg_val,
    output rob_to_lsb_commit, rob_to_lsb_rob_index,
    output rob_clr, rob_to_if_pc
  );

  modport master (
    output issue_ready, issue_rd, issue_is_store, issue_is_branch, issue_pred_jump,
    output cdb_valid, cdb_rob_index, cdb_val, cdb_jump, cdb_target,
    output dc_rs1_depend, dc_rs2_depend,
    input  rob_full, rob_next_index,
    input  rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val,
    input  rob_to_reg_commit, rob_to_reg_rob_index, rob_to_reg_index, rob_to_reg_val,
    input  rob_to_lsb_commit, rob_to_lsb_rob_index,
    input  rob_clr, rob_to_if_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Reorder buffer: 15-entry in-order retirement queue, tags 1..15 (tag 0 means
// "no dependency" and is never allocated).
// Ports:
//   clk_in  : clock
//   rst_in  : synchronous active-high reset, highest priority
//   rdy_in  : global enable; low holds all state, pulses drop to 0
//   bus     : reorder_buffer_if.slave -- issue, CDB, operand query, commit
//             pulses (registered), mispredict flush (rob_clr/rob_to_if_pc)
module reorder_buffer (
  input logic             clk_in,
  input logic             rst_in,
  input logic             rdy_in,
  reorder_buffer_if.slave bus
);

  // Index 0 exists only so 4-bit tags index directly; it is never allocated.
  logic [15:0] busy;
  logic [15:0] ready;
  logic [15:0] is_store;
  logic [15:0] is_branch;
  logic [15:0] pred_jump;
  logic [15:0] jump;
  logic [4:0]  rd     [16];
  logic [31:0] val    [16];
  logic [31:0] target [16];

  logic [3:0] head;
  logic [3:0] tail;
  logic [3:0] count;

  logic issue_fire;
  logic cdb_fire;
  logic commit_fire;
  logic mispredict;

  function automatic logic [3:0] wrap_inc(input logic [3:0] p);
    return (p == 4'd15) ? 4'd1 : p + 4'd1;
  endfunction

  assign bus.rob_full       = (count == 4'd15);
  assign bus.rob_next_index = tail;

  assign issue_fire  = rdy_in && bus.issue_ready && !bus.rob_full && !bus.rob_clr;
  assign cdb_fire    = rdy_in && bus.cdb_valid && !bus.rob_clr && busy[bus.cdb_rob_index];
  assign commit_fire = rdy_in && !bus.rob_clr && busy[head] && ready[head];
  assign mispredict  = commit_fire && is_branch[head] && (jump[head] != pred_jump[head]);

  // Operand query: a completed entry wins; otherwise forward a same-cycle CDB
  // broadcast. CDB is ignored during the flush cycle, so no forwarding then.
  always_comb begin
    bus.rob_rs1_ready = 1'b0;
    bus.rob_rs1_val   = '0;
    bus.rob_rs2_ready = 1'b0;
    bus.rob_rs2_val   = '0;
    if (bus.dc_rs1_depend != 4'd0) begin
      if (busy[bus.dc_rs1_depend] && ready[bus.dc_rs1_depend]) begin
        bus.rob_rs1_ready = 1'b1;
        bus.rob_rs1_val   = val[bus.dc_rs1_depend];
      end else if (bus.cdb_valid && !bus.rob_clr && bus.cdb_rob_index == bus.dc_rs1_depend) begin
        bus.rob_rs1_ready = 1'b1;
        bus.rob_rs1_val   = bus.cdb_val;
      end
    end
    if (bus.dc_rs2_depend != 4'd0) begin
      if (busy[bus.dc_rs2_depend] && ready[bus.dc_rs2_depend]) begin
        bus.rob_rs2_ready = 1'b1;
        bus.rob_rs2_val   = val[bus.dc_rs2_depend];
      end else if (bus.cdb_valid && !bus.rob_clr && bus.cdb_rob_index == bus.dc_rs2_depend) begin
        bus.rob_rs2_ready = 1'b1;
        bus.rob_rs2_val   = bus.cdb_val;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy                     <= '0;
      ready                    <= '0;
      head                     <= 4'd1;
      tail                     <= 4'd1;
      count                    <= '0;
      bus.rob_to_reg_commit    <= 1'b0;
      bus.rob_to_reg_rob_index <= '0;
      bus.rob_to_reg_index     <= '0;
      bus.rob_to_reg_val       <= '0;
      bus.rob_to_lsb_commit    <= 1'b0;
      bus.rob_to_lsb_rob_index <= '0;
      bus.rob_clr              <= 1'b0;
      bus.rob_to_if_pc         <= '0;
    end else if (rdy_in) begin
      bus.rob_to_reg_commit <= 1'b0;
      bus.rob_to_lsb_commit <= 1'b0;
      bus.rob_clr           <= 1'b0;
      if (mispredict) begin
        // Flush wins over any same-edge issue or CDB update.
        bus.rob_clr      <= 1'b1;
        bus.rob_to_if_pc <= target[head];
        busy             <= '0;
        ready            <= '0;
        head             <= 4'd1;
        tail             <= 4'd1;
        count            <= '0;
      end else begin
        if (commit_fire) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= wrap_inc(head);
          if (is_store[head]) begin
            bus.rob_to_lsb_commit    <= 1'b1;
            bus.rob_to_lsb_rob_index <= head;
          end else if (!is_branch[head]) begin
            bus.rob_to_reg_commit    <= 1'b1;
            bus.rob_to_reg_rob_index <= head;
            bus.rob_to_reg_index     <= rd[head];
            bus.rob_to_reg_val       <= val[head];
          end
        end
        if (issue_fire) begin
          busy[tail]      <= 1'b1;
          ready[tail]     <= 1'b0;
          rd[tail]        <= bus.issue_rd;
          is_store[tail]  <= bus.issue_is_store;
          is_branch[tail] <= bus.issue_is_branch;
          pred_jump[tail] <= bus.issue_pred_jump;
          tail            <= wrap_inc(tail);
        end
        if (cdb_fire) begin
          ready[bus.cdb_rob_index]  <= 1'b1;
          val[bus.cdb_rob_index]    <= bus.cdb_val;
          jump[bus.cdb_rob_index]   <= bus.cdb_jump;
          target[bus.cdb_rob_index] <= bus.cdb_target;
        end
        count <= count + {3'b000, issue_fire} - {3'b000, commit_fire};
      end
    end else begin
      bus.rob_to_reg_commit <= 1'b0;
      bus.rob_to_lsb_commit <= 1'b0;
      bus.rob_clr           <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;

  reorder_buffer_if bus();

  reorder_buffer dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_ready     = 1'b0;
    bus.issue_rd        = '0;
    bus.issue_is_store  = 1'b0;
    bus.issue_is_branch = 1'b0;
    bus.issue_pred_jump = 1'b0;
    bus.cdb_valid       = 1'b0;
    bus.cdb_rob_index   = '0;
    bus.cdb_val         = '0;
    bus.cdb_jump        = 1'b0;
    bus.cdb_target      = '0;
    bus.dc_rs1_depend   = '0;
    bus.dc_rs2_depend   = '0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] v, input logic j, input logic [31:0] t);
    bus.cdb_valid     = 1'b1;
    bus.cdb_rob_index = tag;
    bus.cdb_val       = v;
    bus.cdb_jump      = j;
    bus.cdb_target    = t;
  endtask

  initial begin
    idle_inputs();

    // reset
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("rst_full",     32'(bus.rob_full), 0);
    chk("rst_next",     32'(bus.rob_next_index), 1);
    chk("rst_reg_c",    32'(bus.rob_to_reg_commit), 0);
    chk("rst_lsb_c",    32'(bus.rob_to_lsb_commit), 0);
    chk("rst_clr",      32'(bus.rob_clr), 0);
    chk("rst_pc",       bus.rob_to_if_pc, 0);
    chk("rst_reg_val",  bus.rob_to_reg_val, 0);

    // single register op: issue rd=5 at tag 1, complete, commit next edge
    bus.issue_ready = 1'b1; bus.issue_rd = 5'd5;
    tick();
    idle_inputs();
    chk("iss1_next", 32'(bus.rob_next_index), 2);
    cdb(4'd1, 32'h1234, 1'b0, 32'h0);
    bus.dc_rs1_depend = 4'd1;
    #1;
    chk("fwd1_rdy", 32'(bus.rob_rs1_ready), 1);
    chk("fwd1_val", bus.rob_rs1_val, 32'h1234);
    tick();
    bus.cdb_valid = 1'b0;
    chk("c1_early", 32'(bus.rob_to_reg_commit), 0);
    #1;
    chk("q1_rdy", 32'(bus.rob_rs1_ready), 1);
    chk("q1_val", bus.rob_rs1_val, 32'h1234);
    tick();
    chk("c1_pulse", 32'(bus.rob_to_reg_commit), 1);
    chk("c1_tag",   32'(bus.rob_to_reg_rob_index), 1);
    chk("c1_rd",    32'(bus.rob_to_reg_index), 5);
    chk("c1_val",   bus.rob_to_reg_val, 32'h1234);
    chk("c1_lsb",   32'(bus.rob_to_lsb_commit), 0);
    tick();
    chk("c1_drop",  32'(bus.rob_to_reg_commit), 0);
    idle_inputs();

    // out-of-order completion: tags 2 (rd 7) and 3 (rd 8); 3 finishes first
    bus.issue_ready = 1'b1; bus.issue_rd = 5'd7;
    tick();
    bus.issue_rd = 5'd8;
    tick();
    idle_inputs();
    chk("ooo_next", 32'(bus.rob_next_index), 4);
    cdb(4'd3, 32'h33, 1'b0, 32'h0);
    tick();
    idle_inputs();
    tick();
    chk("ooo_hold1", 32'(bus.rob_to_reg_commit), 0);
    cdb(4'd2, 32'h22, 1'b0, 32'h0);
    tick();
    idle_inputs();
    chk("ooo_hold2", 32'(bus.rob_to_reg_commit), 0);
    tick();
    chk("ooo_c2",     32'(bus.rob_to_reg_commit), 1);
    chk("ooo_c2_tag", 32'(bus.rob_to_reg_rob_index), 2);
    chk("ooo_c2_val", bus.rob_to_reg_val, 32'h22);
    tick();
    chk("ooo_c3",     32'(bus.rob_to_reg_commit), 1);
    chk("ooo_c3_tag", 32'(bus.rob_to_reg_rob_index), 3);
    chk("ooo_c3_rd",  32'(bus.rob_to_reg_index), 8);
    chk("ooo_c3_val", bus.rob_to_reg_val, 32'h33);
    tick();
    chk("ooo_drop",   32'(bus.rob_to_reg_commit), 0);

    // CDB forwarding for a tag that is not busy; tag 0 never ready
    cdb(4'd3, 32'hAB, 1'b0, 32'h0);
    bus.dc_rs1_depend = 4'd3;
    bus.dc_rs2_depend = 4'd0;
    #1;
    chk("fwd3_rdy",  32'(bus.rob_rs1_ready), 1);
    chk("fwd3_val",  bus.rob_rs1_val, 32'hAB);
    chk("tag0_rdy",  32'(bus.rob_rs2_ready), 0);
    chk("tag0_val",  bus.rob_rs2_val, 0);
    bus.dc_rs2_depend = 4'd5;
    #1;
    chk("nb5_rdy",   32'(bus.rob_rs2_ready), 0);
    idle_inputs();
    tick();

    // mispredict: branch at tag 4 (pred 0), reg op at tag 5
    bus.issue_ready = 1'b1; bus.issue_is_branch = 1'b1; bus.issue_pred_jump = 1'b0;
    tick();
    bus.issue_is_branch = 1'b0; bus.issue_rd = 5'd9;
    tick();
    idle_inputs();
    chk("br_next", 32'(bus.rob_next_index), 6);
    cdb(4'd4, 32'h0, 1'b1, 32'h80);
    tick();
    idle_inputs();
    bus.issue_ready = 1'b1; bus.issue_rd = 5'd3;   // discarded by flush
    tick();
    chk("mp_clr",   32'(bus.rob_clr), 1);
    chk("mp_pc",    bus.rob_to_if_pc, 32'h80);
    chk("mp_next",  32'(bus.rob_next_index), 1);
    chk("mp_full",  32'(bus.rob_full), 0);
    chk("mp_reg_c", 32'(bus.rob_to_reg_commit), 0);
    tick();                                        // issue ignored while rob_clr
    chk("mp_clr_drop", 32'(bus.rob_clr), 0);
    chk("mp_next2",    32'(bus.rob_next_index), 1);
    idle_inputs();

    // store at tag 1, commit delayed by rdy_in low
    bus.issue_ready = 1'b1; bus.issue_is_store = 1'b1;
    tick();
    idle_inputs();
    cdb(4'd1, 32'h0, 1'b0, 32'h0);
    tick();
    idle_inputs();
    rdy_in = 1'b0;
    bus.issue_ready = 1'b1;                        // held off by rdy_in
    tick();
    tick();
    chk("st_hold_lsb",  32'(bus.rob_to_lsb_commit), 0);
    chk("st_hold_next", 32'(bus.rob_next_index), 2);
    bus.issue_ready = 1'b0;
    rdy_in = 1'b1;
    tick();
    chk("st_lsb_c",   32'(bus.rob_to_lsb_commit), 1);
    chk("st_lsb_tag", 32'(bus.rob_to_lsb_rob_index), 1);
    chk("st_reg_c",   32'(bus.rob_to_reg_commit), 0);
    tick();
    chk("st_drop",    32'(bus.rob_to_lsb_commit), 0);

    // correctly predicted branch at tag 2: no pulses, no flush
    bus.issue_ready = 1'b1; bus.issue_is_branch = 1'b1; bus.issue_pred_jump = 1'b1;
    tick();
    idle_inputs();
    cdb(4'd2, 32'h0, 1'b1, 32'h44);
    tick();
    idle_inputs();
    tick();
    chk("okbr_clr",  32'(bus.rob_clr), 0);
    chk("okbr_reg",  32'(bus.rob_to_reg_commit), 0);
    chk("okbr_lsb",  32'(bus.rob_to_lsb_commit), 0);
    chk("okbr_next", 32'(bus.rob_next_index), 3);

    // reset has priority over a concurrent issue
    rst_in = 1'b1; bus.issue_ready = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("rst2_next", 32'(bus.rob_next_index), 1);

    // fill all 15 entries (issue_ready still high; tail wraps back to 1)
    for (int i = 1; i <= 15; i++) begin
      bus.issue_rd = 5'(i);
      tick();
    end
    chk("full_flag", 32'(bus.rob_full), 1);
    chk("full_next", 32'(bus.rob_next_index), 1);
    tick();                                        // 16th issue ignored
    chk("full_16th",  32'(bus.rob_full), 1);
    chk("full_16nxt", 32'(bus.rob_next_index), 1);
    cdb(4'd1, 32'h11, 1'b0, 32'h0);
    tick();
    bus.cdb_valid = 1'b0;
    chk("full_wait", 32'(bus.rob_full), 1);
    tick();                                        // commit of tag 1; issue still blocked
    chk("full_c1",     32'(bus.rob_to_reg_commit), 1);
    chk("full_c1_val", bus.rob_to_reg_val, 32'h11);
    chk("full_c1_rd",  32'(bus.rob_to_reg_index), 1);
    chk("full_free",   32'(bus.rob_full), 0);
    chk("full_wrap",   32'(bus.rob_next_index), 1);
    tick();                                        // issue re-uses tag 1
    chk("refill_full", 32'(bus.rob_full), 1);
    chk("refill_next", 32'(bus.rob_next_index), 2);
    idle_inputs();

    // reset while full
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("rst3_full", 32'(bus.rob_full), 0);
    chk("rst3_next", 32'(bus.rob_next_index), 1);
    chk("rst3_reg",  32'(bus.rob_to_reg_val), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
